fetch_insn_read_stage: RTL and testbench
========================================

// Module: fetch_insn_read_stage
// PURPOSE
//  Consumer end of the fetch address-translate stage interface (valid, fault, pc_vaddr, pc_paddr).
//  Issues one instruction read per translated PC on a valid/ready memory request port.
//  Waits for the response and holds the result for the decode stage.
//  Back-pressures the translate stage via stall. Drops/drains work on pipeline flush.
// PARAMETERS
//  VADDR_WIDTH  32  virtual PC width (vaddr_t)
//  PADDR_WIDTH  34  physical PC width (paddr_t, Sv32)
//  INSN_WIDTH   32  instruction / response data width
// PORTS
//  clk             in   1       clock; all state on rising edge
//  rst_n           in   1       async active-low reset
//  in_valid        in   1       translate stage has a PC this cycle
//  in_fault        in   1       translation faulted (page/access fault)
//  in_pc_vaddr     in   VADDR   virtual PC
//  in_pc_paddr     in   PADDR   physical PC
//  stall           out  1       translate stage must hold its outputs
//  flush           in   1       pipeline flush (branch/trap); discards in-flight work
//  mem_req_valid   out  1       read request valid
//  mem_req_ready   in   1       memory accepts request
//  mem_req_addr    out  PADDR   request physical address
//  mem_resp_valid  in   1       read data valid
//  mem_resp_data   in   INSN    read data
//  out_valid       out  1       result valid to decode
//  out_fault       out  1       result is a fetch fault (out_insn = 0)
//  out_pc_vaddr    out  VADDR   PC of result
//  out_insn        out  INSN    fetched instruction
//  next_stall      in   1       decode cannot accept result this cycle
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  Reset (rst_n=0, any time): state=IDLE.
//  Reset values: all outputs 0, including stall, mem_req_valid, and all data registers.
//  Memory responses to requests issued before reset are ignored; the memory shares this reset.
//  States:
//   IDLE   stall=0
//          in_valid & !flush & !in_fault -> capture vaddr/paddr; go REQ
//          in_valid & !flush & in_fault  -> capture vaddr; out_fault=1, out_insn=0; go HOLD
//          flush | !in_valid -> stay
//   REQ    mem_req_valid=1, mem_req_addr=captured paddr, stall=1
//          ready & !flush -> WAIT; ready & flush -> DRAIN; !ready & flush -> IDLE
//          Request retraction is allowed only on flush.
//   WAIT   stall=1
//          resp_valid & !flush -> latch data into out_insn, out_fault=0; go HOLD
//          flush -> DRAIN; if resp_valid in the same cycle -> IDLE, data dropped
//   DRAIN  stall=1; out_valid=0; discard next resp_valid and go IDLE; flush here has no extra effect
//   HOLD   out_valid=1, stall=1, outputs stable while next_stall=1
//          !next_stall | flush -> IDLE, out_valid=0 next cycle
//  Response protocol:
//   Memory returns exactly one response per accepted request, in order, >=1 cycle after handshake.
//   resp_valid outside WAIT/DRAIN is ignored.
//  At most one outstanding request.
//  Latency: accept at t -> req at t+1 -> resp earliest t+2 -> out_valid at t+3.
//  Peak throughput: 1 instruction per 4 cycles.
//  out_pc_vaddr / out_insn change only on entry to HOLD.
//  mem_req_addr is constant while mem_req_valid=1.
// TESTING
//  1. Basic read: paddr=0x0_8000_0000, ready=1, resp 1 cycle later data=0x00000013
//     -> out_valid at t+3, out_insn=0x13, out_pc_vaddr correct, stall high t+1..t+3.
//  2. Fault: in_valid=1, in_fault=1, vaddr=0x1000
//     -> no mem_req_valid; next cycle out_valid=1, out_fault=1, out_insn=0.
//  3. Back-pressure: ready low 3 cycles, then next_stall high 2 cycles
//     -> mem_req_addr stable throughout; out_* stable during stall; IDLE after release.
//  4. Flush in WAIT, response 2 cycles later with data 0xDEADBEEF -> data dropped, no out_valid.
//     A new PC accepted after DRAIN returns its own data.
//  5. Flush coincident with handshake -> DRAIN. Flush with ready=0 in REQ -> mem_req_valid drops next cycle, IDLE.
//  6. rst_n low mid-WAIT -> all outputs 0 immediately (async); resumes cleanly after rst_n high.

Source files
------------

// File: rtl/fetch_insn_read_stage.sv
// -----------------------------------------------------------------------------
// fetch_insn_read_stage
//
// Consumer end of the fetch address-translate stage. For every translated PC it
// issues one instruction read on a valid/ready memory request port, waits for
// the single in-order response and holds the result for decode until decode
// takes it. Translation faults skip memory and are reported as a fetch fault.
// A pipeline flush abandons the current PC. A request the memory has already
// accepted still owes one response, which is drained and discarded before a
// new PC is taken.
//
// At most one request is outstanding. The translate stage is stalled in every
// state except IDLE. Best case is one instruction every four cycles.
// -----------------------------------------------------------------------------
module fetch_insn_read_stage #(
  parameter int unsigned VADDR_WIDTH = 32,
  parameter int unsigned PADDR_WIDTH = 34,
  parameter int unsigned INSN_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  // translate stage
  input  logic                   in_valid,
  input  logic                   in_fault,
  input  logic [VADDR_WIDTH-1:0] in_pc_vaddr,
  input  logic [PADDR_WIDTH-1:0] in_pc_paddr,
  output logic                   stall,
  // pipeline control
  input  logic                   flush,
  // memory request / response
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [PADDR_WIDTH-1:0] mem_req_addr,
  input  logic                   mem_resp_valid,
  input  logic [INSN_WIDTH-1:0]  mem_resp_data,
  // decode stage
  output logic                   out_valid,
  output logic                   out_fault,
  output logic [VADDR_WIDTH-1:0] out_pc_vaddr,
  output logic [INSN_WIDTH-1:0]  out_insn,
  input  logic                   next_stall
);

  // ---------------------------------------------------------------------------
  // State encoding
  //   IDLE  : ready to take a PC from translate
  //   REQ   : presenting the read request to memory
  //   WAIT  : request accepted, waiting for the response
  //   DRAIN : flushed after acceptance, discarding the owed response
  //   HOLD  : result presented to decode
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HOLD  = 3'd4
  } state_e;

  state_e state_q, state_d;

  // PC captured on acceptance, used for the request and for the result tag.
  logic [VADDR_WIDTH-1:0] req_vaddr_q, req_vaddr_d;
  logic [PADDR_WIDTH-1:0] req_paddr_q, req_paddr_d;

  // Result registers presented to decode; they only change on entry to HOLD.
  logic [VADDR_WIDTH-1:0] out_pc_vaddr_q, out_pc_vaddr_d;
  logic [INSN_WIDTH-1:0]  out_insn_q,     out_insn_d;
  logic                   out_fault_q,    out_fault_d;

  // ---------------------------------------------------------------------------
  // Decoded events shared by the next-state and datapath logic
  // ---------------------------------------------------------------------------
  logic accept_pc;    // IDLE takes a PC from translate
  logic accept_ok;    // ... and the PC translated cleanly
  logic accept_flt;   // ... and the PC faulted
  logic resp_taken;   // WAIT receives the response that becomes the result
  logic hold_release; // decode consumes the result or a flush discards it

  assign accept_pc    = (state_q == ST_IDLE) && in_valid && !flush;
  assign accept_ok    = accept_pc && !in_fault;
  assign accept_flt   = accept_pc &&  in_fault;
  assign resp_taken   = (state_q == ST_WAIT) && mem_resp_valid && !flush;
  assign hold_release = (state_q == ST_HOLD) && (!next_stall || flush);

  // ---------------------------------------------------------------------------
  // FSM process 1: state register
  // ---------------------------------------------------------------------------
  // Holds the current control state; reset returns to IDLE at any time.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values regardless of the order blocks are evaluated in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 2: next-state logic
  // ---------------------------------------------------------------------------
  // Chooses the next state from the current state, handshakes and flush.
  // NOTE: state_d is given a default before the case so that no path leaves it
  // unassigned; an unassigned path in always_comb would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept_ok) begin
          state_d = ST_REQ;
        end else if (accept_flt) begin
          state_d = ST_HOLD;
        end
      end

      ST_REQ: begin
        // Once accepted, the response is owed even if flushed; without an
        // acceptance the request may simply be withdrawn on flush.
        if (mem_req_ready) begin
          state_d = flush ? ST_DRAIN : ST_WAIT;
        end else if (flush) begin
          state_d = ST_IDLE;
        end
      end

      ST_WAIT: begin
        if (flush) begin
          // A response arriving with the flush settles the debt right away.
          state_d = mem_resp_valid ? ST_IDLE : ST_DRAIN;
        end else if (mem_resp_valid) begin
          state_d = ST_HOLD;
        end
      end

      ST_DRAIN: begin
        // Flush here changes nothing: the work is already being discarded.
        if (mem_resp_valid) begin
          state_d = ST_IDLE;
        end
      end

      ST_HOLD: begin
        if (hold_release) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: state-decoded outputs
  // ---------------------------------------------------------------------------
  // Drives the handshake/status outputs purely from the current state so they
  // never depend combinationally on same-cycle inputs.
  always_comb begin
    stall         = 1'b0;
    mem_req_valid = 1'b0;
    out_valid     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        stall = 1'b0;
      end
      ST_REQ: begin
        stall         = 1'b1;
        mem_req_valid = 1'b1;
      end
      ST_WAIT: begin
        stall = 1'b1;
      end
      ST_DRAIN: begin
        stall = 1'b1;
      end
      ST_HOLD: begin
        stall     = 1'b1;
        out_valid = 1'b1;
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next values
  // ---------------------------------------------------------------------------
  // Captures the PC on acceptance and loads the result registers on HOLD entry.
  always_comb begin
    req_vaddr_d    = req_vaddr_q;
    req_paddr_d    = req_paddr_q;
    out_pc_vaddr_d = out_pc_vaddr_q;
    out_insn_d     = out_insn_q;
    out_fault_d    = out_fault_q;

    if (accept_ok) begin
      req_vaddr_d = in_pc_vaddr;
      req_paddr_d = in_pc_paddr;
    end

    // A faulting PC goes straight to HOLD with an all-zero instruction. The
    // request address register is untouched since no request is issued.
    if (accept_flt) begin
      out_pc_vaddr_d = in_pc_vaddr;
      out_insn_d     = '0;
      out_fault_d    = 1'b1;
    end

    if (resp_taken) begin
      out_pc_vaddr_d = req_vaddr_q;
      out_insn_d     = mem_resp_data;
      out_fault_d    = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // Stores the captured PC and the decode-facing result.
  // NOTE: these are ordinary flops, not a memory array, so they take the async
  // reset; every output must read 0 as soon as rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_vaddr_q    <= '0;
      req_paddr_q    <= '0;
      out_pc_vaddr_q <= '0;
      out_insn_q     <= '0;
      out_fault_q    <= 1'b0;
    end else begin
      req_vaddr_q    <= req_vaddr_d;
      req_paddr_q    <= req_paddr_d;
      out_pc_vaddr_q <= out_pc_vaddr_d;
      out_insn_q     <= out_insn_d;
      out_fault_q    <= out_fault_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output wiring
  // ---------------------------------------------------------------------------
  // The request address is the captured paddr; it is loaded only from IDLE,
  // so it cannot move while a request is presented.
  assign mem_req_addr = req_paddr_q;
  assign out_pc_vaddr = out_pc_vaddr_q;
  assign out_insn     = out_insn_q;
  assign out_fault    = out_fault_q;

  // ---------------------------------------------------------------------------
  // Protocol properties
  // ---------------------------------------------------------------------------
  // A pending request is only ever withdrawn by a flush, and its address holds.
  a_req_held: assert property (@(posedge clk) disable iff (!rst_n)
    (mem_req_valid && !mem_req_ready && !flush)
      |=> (mem_req_valid && $stable(mem_req_addr)));

  // Decode sees a stable result while it is stalling.
  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && next_stall && !flush)
      |=> (out_valid && $stable(out_pc_vaddr) && $stable(out_insn)
           && $stable(out_fault)));

  // The encoding never leaves the five defined states.
  a_state_legal: assert property (@(posedge clk) disable iff (!rst_n)
    state_q inside {ST_IDLE, ST_REQ, ST_WAIT, ST_DRAIN, ST_HOLD});

endmodule

// File: tb/tb_fetch_insn_read_stage.sv
// -----------------------------------------------------------------------------
// Testbench for fetch_insn_read_stage: a directed vector table, a hand-written
// asynchronous-reset sequence, then randomized traffic against a
// transaction-level reference model with a small responding memory.
// -----------------------------------------------------------------------------
module tb_fetch_insn_read_stage;

  localparam int VW = 32;
  localparam int PW = 34;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_fault, flush, mem_req_ready, mem_resp_valid, next_stall;
  logic [VW-1:0] in_pc_vaddr;
  logic [PW-1:0] in_pc_paddr;
  logic [IW-1:0] mem_resp_data;
  logic          stall, mem_req_valid, out_valid, out_fault;
  logic [PW-1:0] mem_req_addr;
  logic [VW-1:0] out_pc_vaddr;
  logic [IW-1:0] out_insn;

  int checks = 0;
  int errors = 0;

  fetch_insn_read_stage #(.VADDR_WIDTH(VW), .PADDR_WIDTH(PW), .INSN_WIDTH(IW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_fault      (in_fault),
    .in_pc_vaddr   (in_pc_vaddr),
    .in_pc_paddr   (in_pc_paddr),
    .stall         (stall),
    .flush         (flush),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data (mem_resp_data),
    .out_valid     (out_valid),
    .out_fault     (out_fault),
    .out_pc_vaddr  (out_pc_vaddr),
    .out_insn      (out_insn),
    .next_stall    (next_stall)
  );

  always #5 clk = ~clk;

  // One directed step: inputs held for one cycle, outputs expected after the edge.
  typedef struct {
    logic          iv, ifl, fl, rdy, rv, ns;
    logic [VW-1:0] va;
    logic [PW-1:0] pa;
    logic [IW-1:0] rd;
    logic          e_stall, e_req, e_ov, e_of;
    logic [PW-1:0] e_addr;
    logic [VW-1:0] e_va;
    logic [IW-1:0] e_insn;
  } vec_t;

  localparam int NV = 40;
  vec_t vecs [NV];

  function automatic vec_t mk(logic iv, logic ifl, logic [VW-1:0] va, logic [PW-1:0] pa,
                              logic fl, logic rdy, logic rv, logic [IW-1:0] rd, logic ns,
                              logic e_stall, logic e_req, logic [PW-1:0] e_addr,
                              logic e_ov, logic e_of, logic [VW-1:0] e_va,
                              logic [IW-1:0] e_insn);
    vec_t v;
    v.iv = iv; v.ifl = ifl; v.va = va; v.pa = pa; v.fl = fl; v.rdy = rdy;
    v.rv = rv; v.rd = rd; v.ns = ns;
    v.e_stall = e_stall; v.e_req = e_req; v.e_addr = e_addr; v.e_ov = e_ov;
    v.e_of = e_of; v.e_va = e_va; v.e_insn = e_insn;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_stall, input logic e_req,
                            input logic [PW-1:0] e_addr, input logic e_ov, input logic e_of,
                            input logic [VW-1:0] e_va, input logic [IW-1:0] e_insn);
    check({tag, ".stall"},         64'(stall),         64'(e_stall));
    check({tag, ".mem_req_valid"}, 64'(mem_req_valid), 64'(e_req));
    check({tag, ".mem_req_addr"},  64'(mem_req_addr),  64'(e_addr));
    check({tag, ".out_valid"},     64'(out_valid),     64'(e_ov));
    check({tag, ".out_fault"},     64'(out_fault),     64'(e_of));
    check({tag, ".out_pc_vaddr"},  64'(out_pc_vaddr),  64'(e_va));
    check({tag, ".out_insn"},      64'(out_insn),      64'(e_insn));
  endtask

  task automatic drive(input logic iv, input logic ifl, input logic [VW-1:0] va,
                       input logic [PW-1:0] pa, input logic fl, input logic rdy,
                       input logic rv, input logic [IW-1:0] rd, input logic ns);
    in_valid = iv; in_fault = ifl; in_pc_vaddr = va; in_pc_paddr = pa;
    flush = fl; mem_req_ready = rdy; mem_resp_valid = rv; mem_resp_data = rd;
    next_stall = ns;
  endtask

  task automatic drive_idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  // Reference model state: what the stage owes, not how it sequences it.
  bit            m_busy, m_issue, m_wait, m_drop, m_result, m_fault;
  logic [PW-1:0] m_addr;
  logic [VW-1:0] m_req_va, m_va;
  logic [IW-1:0] m_insn;
  // Responding memory: remaining delay and data per accepted request.
  int unsigned   mem_cnt_q [$];
  logic [IW-1:0] mem_dat_q [$];

  localparam logic [PW-1:0] PA_A = 34'h0_8000_0000;
  localparam logic [PW-1:0] PA_B = 34'h2_0000_0040;
  localparam logic [PW-1:0] PA_C = 34'h0_0000_1000;
  localparam logic [PW-1:0] PA_D = 34'h0_0000_2000;
  localparam logic [PW-1:0] PA_E = 34'h3_FFFF_FFFC;
  localparam logic [PW-1:0] PA_F = 34'h0_0000_3000;
  localparam logic [PW-1:0] PA_G = 34'h0_0000_4000;
  localparam logic [PW-1:0] PA_H = 34'h0_0000_5000;
  localparam logic [IW-1:0] CF   = 32'hCAFE_F00D;
  localparam logic [IW-1:0] D12  = 32'h1234_5678;

  initial begin
    //            iv ifl va            pa          fl rdy rv rd            ns   stall req addr  ov of e_va          e_insn
    // basic read: accept, handshake, response one cycle later, release
    vecs[0]  = mk(1, 0, 32'h0000_2000, PA_A,        0, 0, 0, '0,           0,   1, 1, PA_A, 0, 0, '0,           '0);
    vecs[1]  = mk(0, 0, '0,            '0,          0, 1, 0, '0,           0,   1, 0, PA_A, 0, 0, '0,           '0);
    vecs[2]  = mk(0, 0, '0,            '0,          0, 0, 1, 32'h13,       0,   1, 0, PA_A, 1, 0, 32'h2000,     32'h13);
    vecs[3]  = mk(0, 0, '0,            '0,          0, 0, 0, '0,           0,   0, 0, PA_A, 0, 0, 32'h2000,     32'h13);
    // fault: no request, HOLD with zero instruction, one stalled cycle
    vecs[4]  = mk(1, 1, 32'h0000_1000, 34'h123,     0, 0, 0, '0,           0,   1, 0, PA_A, 1, 1, 32'h1000,     '0);
    vecs[5]  = mk(0, 0, '0,            '0,          0, 0, 0, '0,           1,   1, 0, PA_A, 1, 1, 32'h1000,     '0);
    vecs[6]  = mk(0, 0, '0,            '0,          0, 0, 0, '0,           0,   0, 0, PA_A, 0, 1, 32'h1000,     '0);
    // back-pressure: ready low three cycles, decode stall two cycles
    vecs[7]  = mk(1, 0, 32'h0000_3004, PA_B,        0, 0, 0, '0,           0,   1, 1, PA_B, 0, 1, 32'h1000,     '0);
    vecs[8]  = mk(0, 0, '0,            '0,          0, 0, 0, '0,           0,   1, 1, PA_B, 0, 1, 32'h1000,     '0);
    vecs[9]  = mk(1, 0, 32'h0000_5555, PA_H,        0, 0, 0, '0,           0,   1, 1, PA_B, 0, 1, 32'h1000,     '0);
    vecs[10] = mk(0, 0, '0,            '0,          0, 0, 0, '0,           0,   1, 1, PA_B, 0, 1, 32'h1000,     '0);
    vecs[11] = mk(0, 0, '0,            '0,          0, 1, 0, '0,           0,   1, 0, PA_B, 0, 1, 32'h1000,     '0);
    vecs[12] = mk(0, 0, '0,            '0,          0, 0, 0, '0,           0,   1, 0, PA_B, 0, 1, 32'h1000,     '0);
    vecs[13] = mk(0, 0, '0,            '0,          0, 0, 1, CF,           0,   1, 0, PA_B, 1, 0, 32'h3004,     CF);
    vecs[14] = mk(1, 0, 32'h0000_9999, 34'h1_1111_1111, 0, 0, 0, '0,       1,   1, 0, PA_B, 1, 0, 32'h3004,     CF);
    vecs[15] = mk(0, 0, '0,            '0,          0, 0, 1, 32'h5A5A_5A5A, 1,  1, 0, PA_B, 1, 0, 32'h3004,     CF);
    vecs[16] = mk(0, 0, '0,            '0,          0, 0, 0, '0,           0,   0, 0, PA_B, 0, 0, 32'h3004,     CF);
    // flush in WAIT, late response dropped (flush in DRAIN is harmless), then a clean read
    vecs[17] = mk(1, 0, 32'h0000_4000, PA_C,        0, 0, 0, '0,           0,   1, 1, PA_C, 0, 0, 32'h3004,     CF);
    vecs[18] = mk(0, 0, '0,            '0,          0, 1, 0, '0,           0,   1, 0, PA_C, 0, 0, 32'h3004,     CF);
    vecs[19] = mk(0, 0, '0,            '0,          1, 0, 0, '0,           0,   1, 0, PA_C, 0, 0, 32'h3004,     CF);
    vecs[20] = mk(0, 0, '0,            '0,          1, 0, 0, '0,           0,   1, 0, PA_C, 0, 0, 32'h3004,     CF);
    vecs[21] = mk(0, 0, '0,            '0,          0, 0, 1, 32'hDEAD_BEEF, 0,  0, 0, PA_C, 0, 0, 32'h3004,     CF);
    vecs[22] = mk(1, 0, 32'h0000_5000, PA_D,        0, 0, 0, '0,           0,   1, 1, PA_D, 0, 0, 32'h3004,     CF);
    vecs[23] = mk(0, 0, '0,            '0,          0, 1, 0, '0,           0,   1, 0, PA_D, 0, 0, 32'h3004,     CF);
    vecs[24] = mk(0, 0, '0,            '0,          0, 0, 1, D12,          0,   1, 0, PA_D, 1, 0, 32'h5000,     D12);
    vecs[25] = mk(0, 0, '0,            '0,          0, 0, 0, '0,           0,   0, 0, PA_D, 0, 0, 32'h5000,     D12);
    // flush with handshake -> DRAIN; flush without ready -> IDLE
    vecs[26] = mk(1, 0, 32'hFFFF_FFFC, PA_E,        0, 0, 0, '0,           0,   1, 1, PA_E, 0, 0, 32'h5000,     D12);
    vecs[27] = mk(0, 0, '0,            '0,          1, 1, 0, '0,           0,   1, 0, PA_E, 0, 0, 32'h5000,     D12);
    vecs[28] = mk(0, 0, '0,            '0,          0, 0, 1, 32'hBAD0_BAD0, 0,  0, 0, PA_E, 0, 0, 32'h5000,     D12);
    vecs[29] = mk(1, 0, 32'h0000_6000, PA_F,        0, 0, 0, '0,           0,   1, 1, PA_F, 0, 0, 32'h5000,     D12);
    vecs[30] = mk(0, 0, '0,            '0,          1, 0, 0, '0,           0,   0, 0, PA_F, 0, 0, 32'h5000,     D12);
    // flush blocks acceptance in IDLE; stray response in IDLE ignored
    vecs[31] = mk(1, 0, 32'h0000_6100, PA_G,        1, 0, 0, '0,           0,   0, 0, PA_F, 0, 0, 32'h5000,     D12);
    vecs[32] = mk(0, 0, '0,            '0,          0, 0, 1, 32'h0BAD_F00D, 0,  0, 0, PA_F, 0, 0, 32'h5000,     D12);
    // flush coincident with the response in WAIT -> IDLE, data dropped
    vecs[33] = mk(1, 0, 32'h0000_7000, PA_G,        0, 0, 0, '0,           0,   1, 1, PA_G, 0, 0, 32'h5000,     D12);
    vecs[34] = mk(0, 0, '0,            '0,          0, 1, 0, '0,           0,   1, 0, PA_G, 0, 0, 32'h5000,     D12);
    vecs[35] = mk(0, 0, '0,            '0,          1, 0, 1, 32'hFFFF_0000, 0,  0, 0, PA_G, 0, 0, 32'h5000,     D12);
    // flush while HOLD with decode stalled -> IDLE
    vecs[36] = mk(1, 0, 32'h0000_8000, PA_H,        0, 0, 0, '0,           0,   1, 1, PA_H, 0, 0, 32'h5000,     D12);
    vecs[37] = mk(0, 0, '0,            '0,          0, 1, 0, '0,           0,   1, 0, PA_H, 0, 0, 32'h5000,     D12);
    vecs[38] = mk(0, 0, '0,            '0,          0, 0, 1, 32'h73,       0,   1, 0, PA_H, 1, 0, 32'h8000,     32'h73);
    vecs[39] = mk(0, 0, '0,            '0,          1, 0, 0, '0,           1,   0, 0, PA_H, 0, 0, 32'h8000,     32'h73);

    // ---------------- reset state ----------------
    rst_n = 1'b0;
    drive_idle();
    @(negedge clk);
    check_outs("reset", 0, 0, '0, 0, 0, '0, '0);
    rst_n = 1'b1;

    // ---------------- directed vectors ----------------
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].iv, vecs[i].ifl, vecs[i].va, vecs[i].pa, vecs[i].fl,
            vecs[i].rdy, vecs[i].rv, vecs[i].rd, vecs[i].ns);
      @(negedge clk);
      check_outs($sformatf("vec%0d", i), vecs[i].e_stall, vecs[i].e_req, vecs[i].e_addr,
                 vecs[i].e_ov, vecs[i].e_of, vecs[i].e_va, vecs[i].e_insn);
    end

    // ---------------- async reset mid-WAIT ----------------
    drive(1, 0, 32'hA000_0000, 34'h1_0000_0100, 0, 0, 0, '0, 0);
    @(negedge clk);
    drive(0, 0, '0, '0, 0, 1, 0, '0, 0);
    @(negedge clk);
    drive_idle();
    check_outs("pre_rst_wait", 1, 0, 34'h1_0000_0100, 0, 0, 32'h8000, 32'h73);
    #2 rst_n = 1'b0;
    #1 check_outs("rst_async", 0, 0, '0, 0, 0, '0, '0);
    @(negedge clk);
    drive(0, 0, '0, '0, 0, 0, 1, 32'h1111_1111, 0);
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    @(negedge clk);
    check_outs("rst_release", 0, 0, '0, 0, 0, '0, '0);
    drive(1, 0, 32'h0000_0100, 34'h0_8000_0100, 0, 0, 0, '0, 0);
    @(negedge clk);
    check_outs("resume_req", 1, 1, 34'h0_8000_0100, 0, 0, '0, '0);
    drive(0, 0, '0, '0, 0, 1, 0, '0, 0);
    @(negedge clk);
    drive(0, 0, '0, '0, 0, 0, 1, 32'h93, 0);
    @(negedge clk);
    check_outs("resume_hold", 1, 0, 34'h0_8000_0100, 1, 0, 32'h100, 32'h93);
    drive_idle();
    @(negedge clk);
    check_outs("resume_idle", 0, 0, 34'h0_8000_0100, 0, 0, 32'h100, 32'h93);

    // ---------------- randomized traffic vs. reference model ----------------
    rst_n = 1'b0;
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    m_busy = 0; m_issue = 0; m_wait = 0; m_drop = 0; m_result = 0; m_fault = 0;
    m_addr = '0; m_req_va = '0; m_va = '0; m_insn = '0;
    mem_cnt_q.delete();
    mem_dat_q.delete();

    for (int cyc = 0; cyc < 4000; cyc++) begin
      logic          iv, ifl, fl, rdy, rv, ns;
      logic [VW-1:0] va;
      logic [PW-1:0] pa;
      logic [IW-1:0] rd;

      check_outs("rnd", 1'(m_busy), 1'(m_issue), m_addr, 1'(m_result), 1'(m_fault), m_va, m_insn);

      // memory: answer the oldest accepted request once its delay has run out
      rv = 1'b0;
      rd = 32'($urandom);
      if (mem_cnt_q.size() > 0) begin
        if (mem_cnt_q[0] == 0) begin
          rv = 1'b1;
          rd = mem_dat_q.pop_front();
          void'(mem_cnt_q.pop_front());
        end else begin
          mem_cnt_q[0] = mem_cnt_q[0] - 1;
        end
      end

      iv  = 1'($urandom_range(0, 1));
      ifl = ($urandom_range(0, 5) == 0);
      va  = 32'($urandom);
      pa  = {2'($urandom_range(0, 3)), 32'($urandom)};
      fl  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      ns  = ($urandom_range(0, 2) == 0);

      // a request accepted at this edge is owed exactly one response
      if (m_issue && rdy) begin
        mem_cnt_q.push_back($urandom_range(0, 2));
        mem_dat_q.push_back(32'($urandom));
      end

      drive(iv, ifl, va, pa, fl, rdy, rv, rd, ns);

      // advance the model across the coming edge
      if (!m_busy) begin
        if (iv && !fl) begin
          m_busy = 1;
          if (ifl) begin
            m_result = 1; m_va = va; m_insn = '0; m_fault = 1;
          end else begin
            m_issue = 1; m_req_va = va; m_addr = pa;
          end
        end
      end else if (m_issue) begin
        if (rdy) begin
          m_issue = 0;
          if (fl) m_drop = 1;
          else    m_wait = 1;
        end else if (fl) begin
          m_issue = 0; m_busy = 0;
        end
      end else if (m_wait) begin
        if (fl) begin
          m_wait = 0;
          if (rv) m_busy = 0;
          else    m_drop = 1;
        end else if (rv) begin
          m_wait = 0; m_result = 1; m_va = m_req_va; m_insn = rd; m_fault = 0;
        end
      end else if (m_drop) begin
        if (rv) begin
          m_drop = 0; m_busy = 0;
        end
      end else if (m_result) begin
        if (!ns || fl) begin
          m_result = 0; m_busy = 0;
        end
      end

      @(negedge clk);
    end
    check_outs("rnd_final", 1'(m_busy), 1'(m_issue), m_addr, 1'(m_result), 1'(m_fault), m_va, m_insn);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
